multiplicador_algoritmico: RTL

//  Sequential shift-add inverse of the algorithmic divider: rebuilds Num = Coc*Den + Res

---
 rtl/multiplicador_algoritmico_if.sv | 25 ++
 rtl/multiplicador_algoritmico.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/multiplicador_algoritmico_if.sv
// Handshake and operand bundle for multiplicador_algoritmico.
// master: the requester (drives Start and operands).
// slave:  the multiplier (drives Num/Ovf/Busy/Done).
interface multiplicador_algoritmico_if #(
  parameter int tamanyo = 32
);
  logic               Start;
  logic [tamanyo-1:0] Coc;
  logic [tamanyo-1:0] Den;
  logic [tamanyo-1:0] Res;
  logic [tamanyo-1:0] Num;
  logic               Ovf;
  logic               Busy;
  logic               Done;

  modport master (
    output Start, Coc, Den, Res,
    input  Num, Ovf, Busy, Done
  );

  modport slave (
    input  Start, Coc, Den, Res,
    output Num, Ovf, Busy, Done
  );
endinterface

// File: rtl/multiplicador_algoritmico.sv
// multiplicador_algoritmico: sequential shift-add inverse of the algorithmic
// divider. Rebuilds Num = Coc*Den + Res, one multiplier bit per clock.
// Signed operands are reduced to magnitudes, multiplied unsigned, and the sign
// plus remainder are applied in a single FIX cycle.
// Optional feature macro: MULT_ALG_OVF_EN (builds the Ovf range check; when
// undefined Ovf is tied low and only the low tamanyo product bits are kept).
module multiplicador_algoritmico #(
  parameter int tamanyo = 32
) (
  input  logic                       CLK,
  input  logic                       RSTa,
  multiplicador_algoritmico_if.slave bus
);

  localparam int CW = $clog2(tamanyo);
`ifdef MULT_ALG_OVF_EN
  localparam int AW = 2*tamanyo;
  localparam int RW = 2*tamanyo + 1;
`else
  // Without the range check only the low tamanyo bits of the product matter,
  // so the accumulator and the fix-up adder are kept at tamanyo bits.
  localparam int AW = tamanyo;
  localparam int RW = tamanyo;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [tamanyo-1:0] mcando_q;
  logic [tamanyo-1:0] mdor_q;
  logic               signo_q;
  logic [tamanyo-1:0] res_q;
  logic [AW-1:0]      acc_q;
  logic [CW-1:0]      cnt_q;
  logic [tamanyo-1:0] num_q;
  logic               done_q;
  logic               busy;

  logic [tamanyo-1:0] mag_coc;
  logic [tamanyo-1:0] mag_den;
  logic [AW-1:0]      mcando_ext;
  logic [AW-1:0]      sumando;
  logic [RW-1:0]      acc_ext;
  logic [RW-1:0]      acc_sgn;
  logic [RW-1:0]      res_ext;
  logic [RW-1:0]      r_fix;
  logic               ultimo;

  // Operand magnitudes; -2^(tamanyo-1) maps to itself, which is correct unsigned.
  always_comb begin
    mag_coc = bus.Coc[tamanyo-1] ? -bus.Coc : bus.Coc;
    mag_den = bus.Den[tamanyo-1] ? -bus.Den : bus.Den;
  end

  // Partial product for the current bit and the signed fix-up result.
  always_comb begin
    mcando_ext = AW'(mcando_q);
    sumando    = mcando_ext << cnt_q;
    acc_ext    = RW'(acc_q);
    acc_sgn    = signo_q ? -acc_ext : acc_ext;
    res_ext    = RW'(signed'(res_q));
    r_fix      = acc_sgn + res_ext;
    ultimo     = (cnt_q == CW'(tamanyo-1));
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) estado_q <= IDLE;
    else       estado_q <= estado_d;
  end

  // Next-state and Busy decode.
  always_comb begin
    estado_d = estado_q;
    busy     = 1'b0;
    unique case (estado_q)
      IDLE: if (bus.Start) estado_d = CALC;
      CALC: begin
        busy = 1'b1;
        if (ultimo) estado_d = FIX;
      end
      FIX: begin
        busy     = 1'b1;
        estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  // Datapath: operand latch, shift-add iterations, result/flag registers.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      mcando_q <= '0;
      mdor_q   <= '0;
      signo_q  <= 1'b0;
      res_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      num_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (estado_q)
        IDLE: if (bus.Start) begin
          mcando_q <= mag_coc;
          mdor_q   <= mag_den;
          signo_q  <= bus.Coc[tamanyo-1] ^ bus.Den[tamanyo-1];
          res_q    <= bus.Res;
          acc_q    <= '0;
          cnt_q    <= '0;
        end
        CALC: begin
          if (mdor_q[0]) acc_q <= acc_q + sumando;
          mdor_q <= mdor_q >> 1;
          cnt_q  <= cnt_q + 1'b1;
        end
        FIX: begin
          num_q  <= r_fix[tamanyo-1:0];
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MULT_ALG_OVF_EN
  logic ovf_q;

  // Overflow when the bits above the signed result range are not a pure sign extension.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa)                ovf_q <= 1'b0;
    else if (estado_q == FIX) ovf_q <= ~((&r_fix[RW-1:tamanyo-1]) | ~(|r_fix[RW-1:tamanyo-1]));
  end

  assign bus.Ovf = ovf_q;
`else
  assign bus.Ovf = 1'b0;
`endif

  assign bus.Num  = num_q;
  assign bus.Busy = busy;
  assign bus.Done = done_q;

endmodule
